// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register for the 5-stage in-order integer core.
// It carries the EX result into MEM and returns the partial multiply-accumulate
// state (hilo_temp/cnt) to EX. It also counts valid instructions entering MEM,
// and this count saturates at its maximum value.
// Optional feature: define EX_MEM_HILO_EN to also carry HI/LO writes (ex_whilo/ex_hi/ex_lo).
// Each edge applies the first matching rule: flush, advance (stall[2]=0), bubble
// (stall[3]=0), hold. A stall[3]=1 with stall[2]=0 is treated as advance.
module ex_mem_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall,
  input  logic                flush,
  input  logic                ex_valid,
  input  logic [ADDR_W-1:0]   ex_wd,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic [2*DATA_W-1:0] hilo_temp_i,
  input  logic [CNT_W-1:0]    cnt_i,
`ifdef EX_MEM_HILO_EN
  input  logic                ex_whilo,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  output logic                mem_whilo,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
`endif
  output logic                mem_valid,
  output logic [ADDR_W-1:0]   mem_wd,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [2*DATA_W-1:0] hilo_temp_o,
  output logic [CNT_W-1:0]    cnt_o,
  output logic [31:0]         inst_count
);

  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   wd_q, wd_d;
  logic                wreg_q, wreg_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [2*DATA_W-1:0] hilo_temp_q, hilo_temp_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         inst_count_q, inst_count_d;
`ifdef EX_MEM_HILO_EN
  logic                whilo_q, whilo_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
`endif

  // Only the EX and MEM stall bits matter to this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5:4], stall[1:0]};

  // Next state: flush, then advance, then bubble; otherwise hold.
  always_comb begin
    valid_d      = valid_q;
    wd_d         = wd_q;
    wreg_d       = wreg_q;
    wdata_d      = wdata_q;
    hilo_temp_d  = hilo_temp_q;
    cnt_d        = cnt_q;
    inst_count_d = inst_count_q;
`ifdef EX_MEM_HILO_EN
    whilo_d      = whilo_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
`endif
    if (flush) begin
      valid_d     = 1'b0;
      wd_d        = '0;
      wreg_d      = 1'b0;
      wdata_d     = '0;
      hilo_temp_d = '0;
      cnt_d       = '0;
`ifdef EX_MEM_HILO_EN
      whilo_d     = 1'b0;
      hi_d        = '0;
      lo_d        = '0;
`endif
    end else if (!stall[2]) begin
      valid_d     = ex_valid;
      wd_d        = ex_wd;
      wreg_d      = ex_wreg;
      wdata_d     = ex_wdata;
      hilo_temp_d = '0;
      cnt_d       = '0;
`ifdef EX_MEM_HILO_EN
      whilo_d     = ex_whilo;
      hi_d        = ex_hi;
      lo_d        = ex_lo;
`endif
      if (ex_valid && (inst_count_q != 32'hFFFF_FFFF)) begin
        inst_count_d = inst_count_q + 32'd1;
      end
    end else if (!stall[3]) begin
      // Bubble into MEM while EX keeps iterating its accumulate.
      valid_d     = 1'b0;
      wd_d        = '0;
      wreg_d      = 1'b0;
      wdata_d     = '0;
      hilo_temp_d = hilo_temp_i;
      cnt_d       = cnt_i;
`ifdef EX_MEM_HILO_EN
      whilo_d     = 1'b0;
      hi_d        = '0;
      lo_d        = '0;
`endif
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      wd_q         <= '0;
      wreg_q       <= 1'b0;
      wdata_q      <= '0;
      hilo_temp_q  <= '0;
      cnt_q        <= '0;
      inst_count_q <= '0;
`ifdef EX_MEM_HILO_EN
      whilo_q      <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
`endif
    end else begin
      valid_q      <= valid_d;
      wd_q         <= wd_d;
      wreg_q       <= wreg_d;
      wdata_q      <= wdata_d;
      hilo_temp_q  <= hilo_temp_d;
      cnt_q        <= cnt_d;
      inst_count_q <= inst_count_d;
`ifdef EX_MEM_HILO_EN
      whilo_q      <= whilo_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
`endif
    end
  end

  assign mem_valid   = valid_q;
  assign mem_wd      = wd_q;
  assign mem_wreg    = wreg_q;
  assign mem_wdata   = wdata_q;
  assign hilo_temp_o = hilo_temp_q;
  assign cnt_o       = cnt_q;
  assign inst_count  = inst_count_q;
`ifdef EX_MEM_HILO_EN
  assign mem_whilo   = whilo_q;
  assign mem_hi      = hi_q;
  assign mem_lo      = lo_q;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed vector table, async reset and
// saturation sequences, then random legal stimulus against a reference model.
module tb_ex_mem_reg;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        ex_valid;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [63:0] hilo_temp_i;
  logic [1:0]  cnt_i;
  logic        mem_valid;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;
  logic [31:0] inst_count;
`ifdef EX_MEM_HILO_EN
  logic        ex_whilo;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
`endif

  int total = 0;
  int bad   = 0;

  ex_mem_reg #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .ex_valid    (ex_valid),
    .ex_wd       (ex_wd),
    .ex_wreg     (ex_wreg),
    .ex_wdata    (ex_wdata),
    .hilo_temp_i (hilo_temp_i),
    .cnt_i       (cnt_i),
`ifdef EX_MEM_HILO_EN
    .ex_whilo    (ex_whilo),
    .ex_hi       (ex_hi),
    .ex_lo       (ex_lo),
    .mem_whilo   (mem_whilo),
    .mem_hi      (mem_hi),
    .mem_lo      (mem_lo),
`endif
    .mem_valid   (mem_valid),
    .mem_wd      (mem_wd),
    .mem_wreg    (mem_wreg),
    .mem_wdata   (mem_wdata),
    .hilo_temp_o (hilo_temp_o),
    .cnt_o       (cnt_o),
    .inst_count  (inst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A downstream stall without an upstream stall is illegal.
  always @(posedge clk) begin
    if (rst) begin
      assert (!(stall[3] && !stall[2])) else $error("illegal stall vector %b", stall);
    end
  end

  typedef struct {
    logic        flush;
    logic [5:0]  stall;
    logic        valid;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [63:0] hilo;
    logic [1:0]  cnt;
    // expected after the edge
    logic        e_valid;
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [31:0] e_wdata;
    logic [63:0] e_hilo;
    logic [1:0]  e_cnt;
    logic [31:0] e_ic;
  } vec_t;

  // Reference state of the MEM side, updated by the rule table.
  typedef struct {
    logic        valid;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [63:0] hilo;
    logic [1:0]  cnt;
    logic [31:0] ic;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } model_t;

  model_t m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic [5:0] s, input logic v, input logic [4:0] wd,
                       input logic wr, input logic [31:0] wdat, input logic [63:0] h,
                       input logic [1:0] c);
    flush = f; stall = s; ex_valid = v; ex_wd = wd; ex_wreg = wr; ex_wdata = wdat;
    hilo_temp_i = h; cnt_i = c;
  endtask

  task automatic check_all(input string tag, input logic v, input logic [4:0] wd,
                           input logic wr, input logic [31:0] wdat, input logic [63:0] h,
                           input logic [1:0] c, input logic [31:0] ic);
    check({tag, ".valid"}, 64'(mem_valid), 64'(v));
    check({tag, ".wd"},    64'(mem_wd),    64'(wd));
    check({tag, ".wreg"},  64'(mem_wreg),  64'(wr));
    check({tag, ".wdata"}, 64'(mem_wdata), 64'(wdat));
    check({tag, ".hilo"},  hilo_temp_o,    h);
    check({tag, ".cnt"},   64'(cnt_o),     64'(c));
    check({tag, ".ic"},    64'(inst_count), 64'(ic));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(1'b0, 6'd0, 1'b0, 5'd0, 1'b0, 32'd0, 64'd0, 2'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    m = '{default: '0};
  endtask

  // Spec-level transition: pick the rule, then apply its effect.
  function automatic model_t step(input model_t s, input logic f, input logic [5:0] st,
                                  input logic v, input logic [4:0] wd, input logic wr,
                                  input logic [31:0] wdat, input logic [63:0] h,
                                  input logic [1:0] c, input logic wh,
                                  input logic [31:0] hi, input logic [31:0] lo);
    model_t n = s;
    if (f) begin
      n = '{default: '0};
      n.ic = s.ic;
    end else if (st[2] == 1'b0) begin
      n.valid = v; n.wd = wd; n.wreg = wr; n.wdata = wdat; n.hilo = 0; n.cnt = 0;
      n.whilo = wh; n.hi = hi; n.lo = lo;
      if (v && s.ic < 32'hFFFF_FFFF) n.ic = s.ic + 1;
    end else if (st[3] == 1'b0) begin
      n = '{default: '0};
      n.ic = s.ic; n.hilo = h; n.cnt = c;
    end
    return n;
  endfunction

  vec_t vt[$];

  initial begin
    logic [31:0] rwh;
    logic [31:0] rhi;
    logic [31:0] rlo;
    rst = 1'b0;
    drive(1'b0, 6'd0, 1'b0, 5'd0, 1'b0, 32'd0, 64'd0, 2'd0);
`ifdef EX_MEM_HILO_EN
    ex_whilo = 1'b0; ex_hi = '0; ex_lo = '0;
`endif
    #3;
    check_all("reset", 1'b0, 5'd0, 1'b0, 32'd0, 64'd0, 2'd0, 32'd0);
    do_reset();
    check_all("post_reset", 1'b0, 5'd0, 1'b0, 32'd0, 64'd0, 2'd0, 32'd0);

    // flush stall v wd wreg wdata hilo cnt | expected valid wd wreg wdata hilo cnt ic
    vt.push_back('{0, 6'b000000, 1, 5'd3,  1, 32'h0000_00FF, 64'h0, 2'd0,
                   1, 5'd3, 1, 32'h0000_00FF, 64'h0, 2'd0, 32'd1});
    vt.push_back('{0, 6'b000100, 1, 5'd7,  1, 32'h0000_0123, 64'h1_0000_0002, 2'd1,
                   0, 5'd0, 0, 32'h0, 64'h1_0000_0002, 2'd1, 32'd1});
    vt.push_back('{0, 6'b000000, 1, 5'd4,  0, 32'hA5A5_A5A5, 64'h55, 2'd3,
                   1, 5'd4, 0, 32'hA5A5_A5A5, 64'h0, 2'd0, 32'd2});
    vt.push_back('{0, 6'b001100, 1, 5'd9,  1, 32'h1111_1111, 64'h77, 2'd2,
                   1, 5'd4, 0, 32'hA5A5_A5A5, 64'h0, 2'd0, 32'd2});
    vt.push_back('{0, 6'b111100, 0, 5'd10, 1, 32'h2222_2222, 64'h88, 2'd1,
                   1, 5'd4, 0, 32'hA5A5_A5A5, 64'h0, 2'd0, 32'd2});
    vt.push_back('{0, 6'b001111, 1, 5'd11, 0, 32'h3333_3333, 64'h99, 2'd3,
                   1, 5'd4, 0, 32'hA5A5_A5A5, 64'h0, 2'd0, 32'd2});
    vt.push_back('{1, 6'b001100, 1, 5'd12, 1, 32'h4444_4444, 64'hAA, 2'd2,
                   0, 5'd0, 0, 32'h0, 64'h0, 2'd0, 32'd2});
    vt.push_back('{0, 6'b000000, 0, 5'd2,  1, 32'h0000_DEAD, 64'hBB, 2'd1,
                   0, 5'd2, 1, 32'h0000_DEAD, 64'h0, 2'd0, 32'd2});
    vt.push_back('{0, 6'b000110, 1, 5'd5,  1, 32'h5555_5555, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3,
                   0, 5'd0, 0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 32'd2});
    vt.push_back('{0, 6'b001100, 1, 5'd6,  1, 32'h6666_6666, 64'h12, 2'd1,
                   0, 5'd0, 0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 32'd2});
    vt.push_back('{1, 6'b000000, 1, 5'd8,  1, 32'h7777_7777, 64'h34, 2'd2,
                   0, 5'd0, 0, 32'h0, 64'h0, 2'd0, 32'd2});
    vt.push_back('{0, 6'b110011, 1, 5'd31, 0, 32'h1234_5678, 64'h56, 2'd2,
                   1, 5'd31, 0, 32'h1234_5678, 64'h0, 2'd0, 32'd3});

    foreach (vt[i]) begin
      drive(vt[i].flush, vt[i].stall, vt[i].valid, vt[i].wd, vt[i].wreg, vt[i].wdata,
            vt[i].hilo, vt[i].cnt);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vt[i].e_valid, vt[i].e_wd, vt[i].e_wreg,
                vt[i].e_wdata, vt[i].e_hilo, vt[i].e_cnt, vt[i].e_ic);
    end

    // Async reset mid-hold clears outputs before the next edge.
    drive(1'b0, 6'b000100, 1'b1, 5'd1, 1'b1, 32'd0, 64'hCAFE, 2'd2);
    @(posedge clk);
    #1 drive(1'b0, 6'b001100, 1'b1, 5'd13, 1'b1, 32'h0BAD_F00D, 64'h1, 2'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 5'd0, 1'b0, 32'd0, 64'd0, 2'd0, 32'd0);
    #1 rst = 1'b1;

    // Saturation: preload the counter just below its ceiling.
    do_reset();
    @(negedge clk);
    force dut.inst_count_q = 32'hFFFF_FFFE;
    #1 release dut.inst_count_q;
    #1 check("sat_preload", 64'(inst_count), 64'h0000_0000_FFFF_FFFE);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 6'd0, 1'b1, 5'(k + 1), 1'b1, 32'(k), 64'd0, 2'd0);
      @(posedge clk);
      #1 check($sformatf("sat%0d", k), 64'(inst_count), 64'h0000_0000_FFFF_FFFF);
    end

    // Random legal stimulus against the reference model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [5:0] s;
      logic       f;
      s = 6'($urandom);
      if (s[3]) s[2] = 1'b1;
      f = ($urandom_range(0, 15) == 0);
      rwh = $urandom; rhi = $urandom; rlo = $urandom;
      drive(f, s, 1'($urandom), 5'($urandom), 1'($urandom), $urandom,
            {$urandom, $urandom}, 2'($urandom));
`ifdef EX_MEM_HILO_EN
      ex_whilo = rwh[0]; ex_hi = rhi; ex_lo = rlo;
`endif
      m = step(m, f, s, ex_valid, ex_wd, ex_wreg, ex_wdata, hilo_temp_i, cnt_i,
               rwh[0], rhi, rlo);
      @(posedge clk);
      #1;
      check_all($sformatf("rnd%0d", n), m.valid, m.wd, m.wreg, m.wdata, m.hilo, m.cnt, m.ic);
`ifdef EX_MEM_HILO_EN
      check("rnd.whilo", 64'(mem_whilo), 64'(m.whilo));
      check("rnd.hi",    64'(mem_hi),    64'(m.hi));
      check("rnd.lo",    64'(mem_lo),    64'(m.lo));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
